// File: rtl/zvc_decompressor.sv
// Zero-value decompressor: scatters a compacted LIFM/MT line back to its
// original positions using the occupancy mask, zero-filling empty slots.
// Two-stage valid/ready pipeline: S1 registers the line with its exclusive
// prefix sum, S2 gathers each position's word and holds the output.
module zvc_decompressor #(
   parameter int WORD_WIDTH    = 8,
   parameter int LINE_SIZE     = 32,
   parameter int DIST_WIDTH    = 7,
   parameter int MAX_LIFM_RSIZ = 3,
   parameter int IDX_WIDTH     = 6
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [LINE_SIZE-1:0]                          mask,
   input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
   input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_line,
   output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
   output logic [IDX_WIDTH-1:0]                          nnz
);

   localparam int MT_W = DIST_WIDTH * MAX_LIFM_RSIZ;

   logic                              s1_valid;
   logic [LINE_SIZE-1:0]              s1_mask;
   logic [LINE_SIZE*WORD_WIDTH-1:0]   s1_lifm;
   logic [LINE_SIZE*MT_W-1:0]         s1_mt;
   logic [IDX_WIDTH-1:0]              s1_idx [LINE_SIZE];
   logic [IDX_WIDTH-1:0]              s1_nnz;

   logic [IDX_WIDTH-1:0]              idx_c [LINE_SIZE];
   logic [IDX_WIDTH-1:0]              nnz_c;
   logic [LINE_SIZE*WORD_WIDTH-1:0]   lifm_g;
   logic [LINE_SIZE*MT_W-1:0]         mt_g;
   logic                              s2_load;
   logic                              in_xfer;

   // S2 can take a new line when it is empty or its line leaves this cycle;
   // S1 frees up under the same condition, so in_ready never sees in_valid.
   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;
   assign in_xfer  = in_valid && in_ready;

   // Exclusive prefix popcount of the incoming mask; the final sum is nnz.
   always_comb begin
      nnz_c = '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
         idx_c[i] = nnz_c;
         nnz_c    = nnz_c + IDX_WIDTH'(mask[i]);
      end
   end

   // S1 register: captures the line and its prefix indices on an input transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_mask  <= '0;
         s1_lifm  <= '0;
         s1_mt    <= '0;
         s1_nnz   <= '0;
         for (int i = 0; i < LINE_SIZE; i++) s1_idx[i] <= '0;
      end else begin
         if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_mask  <= mask;
            s1_lifm  <= lifm_comp;
            s1_mt    <= mt_comp;
            s1_nnz   <= nnz_c;
            for (int i = 0; i < LINE_SIZE; i++) s1_idx[i] <= idx_c[i];
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Gather: occupied positions pull compacted word idx[i]; the rest are zero.
   // Only indices below nnz are ever selected, so don't-care words never leak.
   always_comb begin
      lifm_g = '0;
      mt_g   = '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
         if (s1_mask[i]) begin
            lifm_g[i*WORD_WIDTH +: WORD_WIDTH] = s1_lifm[int'(s1_idx[i])*WORD_WIDTH +: WORD_WIDTH];
            mt_g[i*MT_W +: MT_W]               = s1_mt[int'(s1_idx[i])*MT_W +: MT_W];
         end
      end
   end

   // S2 output register: loads when empty or draining, otherwise holds steady.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         lifm_line <= '0;
         mt_line   <= '0;
         nnz       <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            lifm_line <= lifm_g;
            mt_line   <= mt_g;
            nnz       <= s1_nnz;
         end
      end
   end

endmodule

// File: doc/zvc_decompressor.md
Name: zvc_decompressor

Overview:
Inverse of the zero-value compressor. Takes a compacted LIFM line, its compacted mapping-table (MT) line and the per-position occupancy mask, and scatters entries back to their original line positions, zero-filling the empty ones. It sits on the read side of the compressed LIFM buffer, ahead of the PE array feed. It is a 2-stage valid/ready pipeline: prefix-sum, then gather.

Parameters:
WORD_WIDTH, 8, bits per LIFM word
LINE_SIZE, 32, words per line (the prefix logic is sized for 32)
DIST_WIDTH, 7, bits per MT distance field
MAX_LIFM_RSIZ, 3, MT distance fields per word; MT entry width = DIST_WIDTH*MAX_LIFM_RSIZ
IDX_WIDTH, 6, $clog2(LINE_SIZE)+1; width of prefix indices and counts

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input line valid
in_ready  output  1  block can accept a line this cycle
mask  input  LINE_SIZE  bit i=1: original position i holds a nonzero entry
lifm_comp  input  LINE_SIZE*WORD_WIDTH  compacted LIFM; word k at [k*WORD_WIDTH +: WORD_WIDTH]
mt_comp  input  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  compacted MT, same packing
out_valid  output  1  expanded line valid
out_ready  input  1  downstream accepts the output line
lifm_line  output  LINE_SIZE*WORD_WIDTH  expanded LIFM line
mt_line  output  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  expanded MT line
nnz  output  IDX_WIDTH  popcount(mask) of the current output line

Behaviour:
- Reset is asynchronous and active-low on reset_n; the block has one clock, clk. Reset clears all stage registers and valid bits. Reset values: out_valid=0, lifm_line=0, mt_line=0, nnz=0. in_ready=1 in the first cycle after reset_n is released.
- Packing convention: the compressed line holds the nonzero entries at indices 0..nnz-1, in ascending original-position order. Entries at index >= nnz are don't-care and must never reach the output.
- Transfers: an input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- Stage 1 (S1): on an input transfer, register mask, lifm_comp and mt_comp. Compute the exclusive prefix sum idx[i] = popcount(mask[i-1:0]), with idx[0]=0, each IDX_WIDTH bits. Also compute nnz = popcount(mask). Register idx and nnz together with the data. The prefix sum may be computed combinationally before the register or after it, but the S1 register boundary is fixed.
- Stage 2 (S2, the output register): for each position i, lifm_line[i] = mask[i] ? lifm_comp[idx[i]] : 0, and mt_line[i] = mask[i] ? mt_comp[idx[i]] : 0. nnz is passed through.
- Latency: the line accepted at cycle t appears with out_valid=1 at cycle t+2, provided out_ready has been high.
- Throughput: 1 line/cycle when out_ready=1.
- Stall rules:
  - S2 loads when it is empty or an output transfer occurs.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (S1 advances this cycle).
  - in_ready must not depend combinationally on in_valid.
- While a stage is stalled it holds all of its data and must not change outputs; out_valid stays high until the output transfer.
- Simultaneous events: an input transfer, an S1->S2 move and an output transfer may all occur in the same cycle; no line is lost or duplicated.
- Boundary conditions:
  - mask=0: output is all zero and nnz=0; compressed inputs are ignored.
  - mask all ones: output equals the input word-for-word and nnz=32 (IDX_WIDTH must hold 32).
- Reset mid-operation: all in-flight lines are discarded and out_valid drops immediately; nothing is replayed after reset.

Test Plan:
- Identity: mask=0xFFFFFFFF, lifm_comp word k = k+1, mt_comp word k = k; single input at cycle 0 with out_ready=1 -> at cycle 2, out_valid=1, lifm_line word i = i+1, mt_line word i = i, nnz=32.
- Empty: mask=0, lifm_comp words all 0xFF, mt_comp all ones -> lifm_line=0, mt_line=0, nnz=0.
- Sparse ends: mask=0x80000001, lifm_comp[0]=0xAA, lifm_comp[1]=0xBB, remaining words 0x77 -> word 0 = 0xAA, word 31 = 0xBB, all other words 0, nnz=2.
- Alternating: mask=0x55555555, lifm_comp word k = 0x10+k -> output even word 2k = 0x10+k, odd words 0; nnz=16.
- Backpressure: drive 4 back-to-back lines A..D with out_ready=0 for cycles 2-4, then 1 -> in_ready drops after 2 lines are held (S1 and S2 full); output order is A,B,C,D with no loss or duplication; the held output is stable while stalled.
- Reset mid-stream: assert reset_n=0 while S1 and S2 are both valid -> out_valid=0 and all outputs 0 immediately; after release, in_ready=1 and a new line emerges 2 cycles after its acceptance.
